// File: rtl/tcm_sram_pkg.sv
// Shared constants and helpers for the tightly-coupled dual-port SRAM.
package tcm_sram_pkg;

  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned AW_DEF         = 16;
  localparam int unsigned DEPTH_LOG2_DEF = 14;

  typedef enum logic {
    RDW_OLD  = 1'b0,
    RDW_NEWW = 1'b1
  } rdw_mode_e;

  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / 8;
  endfunction

  // Drops the byte-offset bits and wraps the remaining address modulo the depth.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int unsigned off_bits,
                                             input int unsigned depth_log2);
    return (addr >> off_bits) & ((64'd1 << depth_log2) - 64'd1);
  endfunction

endpackage

// File: rtl/tcm_rdpipe.sv
// Extra output register stage for a read port: per-lane data hold plus valid.
module tcm_rdpipe
  import tcm_sram_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   d_i,
  input  logic [DW/8-1:0] be_i,
  input  logic            vld_i,
  output logic [DW-1:0]   q_o,
  output logic            vld_o
);

  localparam int unsigned NL = lane_count(DW);

  logic [DW-1:0] q_q, q_d;
  logic          vld_q;

  always_comb begin
    q_d = q_q;
    for (int unsigned k = 0; k < NL; k++) begin
      if (be_i[k]) q_d[k*8 +: 8] = d_i[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_i;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/tcm_sram.sv
// Dual-port TCM: port A read-only, port B byte read/write, latency 1 or 2.
module tcm_sram
  import tcm_sram_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned LAT        = 1,
  parameter int unsigned RDW_NEW    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ins_a,
  input  logic            ins_e,
  output logic [DW-1:0]   ins,
  output logic            ins_vld,
  input  logic [AW-1:0]   dat_a,
  input  logic [DW/8-1:0] dat_we,
  input  logic [DW-1:0]   dat_wd,
  input  logic [DW/8-1:0] dat_re,
  output logic [DW-1:0]   dat_rd,
  output logic            dat_vld
);

  localparam int unsigned NL    = lane_count(DW);
  localparam int unsigned OFFB  = $clog2(NL);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam rdw_mode_e RDW_MODE = (RDW_NEW != 0) ? RDW_NEWW : RDW_OLD;

  logic [DW-1:0] mem [DEPTH];

  logic [63:0]           a_idx_w, b_idx_w;
  logic [DEPTH_LOG2-1:0] a_idx, b_idx;
  logic                  unused_idx;

  assign a_idx_w    = word_index(64'(ins_a), OFFB, DEPTH_LOG2);
  assign b_idx_w    = word_index(64'(dat_a), OFFB, DEPTH_LOG2);
  assign a_idx      = a_idx_w[DEPTH_LOG2-1:0];
  assign b_idx      = b_idx_w[DEPTH_LOG2-1:0];
  assign unused_idx = ^{a_idx_w[63:DEPTH_LOG2], b_idx_w[63:DEPTH_LOG2]};

  // Writes are masked during reset so requests are ignored without resetting the array.
  logic [NL-1:0] we_eff;
  assign we_eff = dat_we & {NL{~rst}};

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NL; k++) begin
      if (we_eff[k]) mem[b_idx][k*8 +: 8] <= dat_wd[k*8 +: 8];
    end
  end

  logic [DW-1:0] a_old, b_old, a_rd;
  assign a_old = mem[a_idx];
  assign b_old = mem[b_idx];

  always_comb begin
    a_rd = a_old;
    if (RDW_MODE == RDW_NEWW && a_idx == b_idx) begin
      for (int unsigned k = 0; k < NL; k++) begin
        if (we_eff[k]) a_rd[k*8 +: 8] = dat_wd[k*8 +: 8];
      end
    end
  end

  logic [DW-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
  logic [NL-1:0] a_be_q, b_be_q;
  logic          a_vld_q, b_vld_q;

  always_comb begin
    a_dat_d = a_dat_q;
    if (ins_e) a_dat_d = a_rd;
    b_dat_d = b_dat_q;
    for (int unsigned k = 0; k < NL; k++) begin
      if (dat_re[k]) b_dat_d[k*8 +: 8] = b_old[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dat_q <= '0;
      a_vld_q <= 1'b0;
      a_be_q  <= '0;
      b_dat_q <= '0;
      b_vld_q <= 1'b0;
      b_be_q  <= '0;
    end else begin
      a_dat_q <= a_dat_d;
      a_vld_q <= ins_e;
      a_be_q  <= {NL{ins_e}};
      b_dat_q <= b_dat_d;
      b_vld_q <= |dat_re;
      b_be_q  <= dat_re;
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      tcm_rdpipe #(.DW(DW)) u_pipe_a (
        .clk   (clk),
        .rst   (rst),
        .d_i   (a_dat_q),
        .be_i  (a_be_q),
        .vld_i (a_vld_q),
        .q_o   (ins),
        .vld_o (ins_vld)
      );
      tcm_rdpipe #(.DW(DW)) u_pipe_b (
        .clk   (clk),
        .rst   (rst),
        .d_i   (b_dat_q),
        .be_i  (b_be_q),
        .vld_i (b_vld_q),
        .q_o   (dat_rd),
        .vld_o (dat_vld)
      );
    end else begin : g_lat1
      logic unused_be;
      assign unused_be = ^{a_be_q, b_be_q};
      assign ins     = a_dat_q;
      assign ins_vld = a_vld_q;
      assign dat_rd  = b_dat_q;
      assign dat_vld = b_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_tcm_sram.sv
// Bench for tcm_sram: two instances (LAT=1/old-data, LAT=2/new-data) against a word-array model.
module tb_tcm_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] ins_a  = '0;
  logic        ins_e  = 1'b0;
  logic [17:0] dat_a  = '0;
  logic [3:0]  dat_we = '0;
  logic [31:0] dat_wd = '0;
  logic [3:0]  dat_re = '0;

  logic [31:0] ins_d [2];
  logic [31:0] rd_d  [2];
  logic        iv_d  [2];
  logic        dv_d  [2];

  always #5 clk = ~clk;

  tcm_sram #(.DW(32), .AW(18), .DEPTH_LOG2(14), .LAT(1), .RDW_NEW(0)) dut0 (
    .clk(clk), .rst(rst), .ins_a(ins_a), .ins_e(ins_e), .ins(ins_d[0]), .ins_vld(iv_d[0]),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
    .dat_rd(rd_d[0]), .dat_vld(dv_d[0])
  );

  tcm_sram #(.DW(32), .AW(18), .DEPTH_LOG2(14), .LAT(2), .RDW_NEW(1)) dut1 (
    .clk(clk), .rst(rst), .ins_a(ins_a), .ins_e(ins_e), .ins(ins_d[1]), .ins_vld(iv_d[1]),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
    .dat_rd(rd_d[1]), .dat_vld(dv_d[1])
  );

  typedef struct {
    bit          e;
    logic [31:0] aw;
    logic [3:0]  re;
    logic [31:0] bw;
  } txn_t;

  logic [31:0] mem_m [int];
  txn_t        q0[$];
  txn_t        q1[$];
  logic [31:0] ins_m [2];
  logic [31:0] rd_m  [2];
  bit          iv_m  [2];
  bit          dv_m  [2];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  function automatic int widx(input logic [17:0] a);
    int t;
    t = int'(a);
    return (t / 4) % 16384;
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      ins_m[k] = '0; rd_m[k] = '0; iv_m[k] = 0; dv_m[k] = 0;
    end
  endfunction

  function automatic void retire(input int k, input txn_t t);
    iv_m[k] = t.e;
    if (t.e) ins_m[k] = t.aw;
    dv_m[k] = |t.re;
    for (int l = 0; l < 4; l++)
      if (t.re[l]) rd_m[k][l*8 +: 8] = t.bw[l*8 +: 8];
  endfunction

  // One clock of requests; model expectations are updated, outputs sampled at edge+1.
  task automatic step(input logic [17:0] ia, input bit ie, input logic [17:0] da,
                      input logic [3:0] we, input logic [31:0] wd, input logic [3:0] re);
    txn_t t0, t1;
    logic [31:0] olda, oldb, newb;
    ins_a = ia; ins_e = ie; dat_a = da; dat_we = we; dat_wd = wd; dat_re = re;
    olda = mem_m.exists(widx(ia)) ? mem_m[widx(ia)] : 32'h0;
    oldb = mem_m.exists(widx(da)) ? mem_m[widx(da)] : 32'h0;
    newb = oldb;
    for (int l = 0; l < 4; l++)
      if (we[l]) newb[l*8 +: 8] = wd[l*8 +: 8];
    t0 = '{e: ie, aw: olda, re: re, bw: oldb};
    t1 = '{e: ie, aw: (widx(ia) == widx(da)) ? newb : olda, re: re, bw: oldb};
    if (we != 4'h0) mem_m[widx(da)] = newb;
    q0.push_back(t0);
    q1.push_back(t1);
    @(posedge clk);
    #1;
    if (q0.size() >= 1) retire(0, q0.pop_front());
    else begin iv_m[0] = 0; dv_m[0] = 0; end
    if (q1.size() >= 2) retire(1, q1.pop_front());
    else begin iv_m[1] = 0; dv_m[1] = 0; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 0, '0, 4'h0, '0, 4'h0);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    ins_e = 1'b1; dat_we = 4'hF; dat_re = 4'hF; dat_wd = 32'h5A5A5A5A;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ins_d[k] !== 32'h0 || rd_d[k] !== 32'h0 || iv_d[k] !== 1'b0 || dv_d[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_probe dut%0d: ins=%h rd=%h iv=%b dv=%b, want all 0",
                 k, ins_d[k], rd_d[k], iv_d[k], dv_d[k]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step('0, 0, '0, 4'h0, '0, 4'h0);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (ins_d[k] !== 32'h0 || rd_d[k] !== 32'h0 || iv_d[k] !== 1'b0 || dv_d[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_release dut%0d: ins=%h rd=%h iv=%b dv=%b, want all 0",
                   k, ins_d[k], rd_d[k], iv_d[k], dv_d[k]);
        end
      end
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 64; w++) step('0, 0, 18'(w * 4), 4'hF, $urandom, 4'h0);
  endtask

  task automatic test_byte_write();
    step('0, 0, 18'h10, 4'hF, 32'hDEADBEEF, 4'h0);
    step('0, 0, 18'h10, 4'b0100, 32'h00550000, 4'h0);
    step(18'h10, 1, 18'h10, 4'h0, '0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (dv_d[k] !== dv_m[k] || iv_d[k] !== iv_m[k]) begin
          n_fail++;
          $display("FAIL byte_vld dut%0d step%0d: dv=%b iv=%b, want dv=%b iv=%b",
                   k, i, dv_d[k], iv_d[k], dv_m[k], iv_m[k]);
        end
      end
      step('0, 0, '0, 4'h0, '0, 4'h0);
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd_d[k] !== 32'hDE55BEEF || ins_d[k] !== 32'hDE55BEEF) begin
        n_fail++;
        $display("FAIL byte_write dut%0d: rd=%h ins=%h, want DE55BEEF", k, rd_d[k], ins_d[k]);
      end
    end
  endtask

  task automatic test_lane_hold();
    step('0, 0, 18'h30, 4'hF, 32'h11223344, 4'h0);
    step('0, 0, 18'h34, 4'hF, 32'hAABBCCDD, 4'h0);
    step('0, 0, 18'h30, 4'h0, '0, 4'hF);
    step('0, 0, 18'h34, 4'h0, '0, 4'b0011);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd_d[k] !== 32'h1122CCDD) begin
        n_fail++;
        $display("FAIL lane_hold dut%0d: rd=%h, want 1122CCDD", k, rd_d[k]);
      end
    end
  endtask

  task automatic test_rdw();
    step('0, 0, 18'h20, 4'hF, 32'h0, 4'h0);
    step(18'h20, 1, 18'h20, 4'hF, 32'h12345678, 4'hF);
    idle(2);
    n_chk++;
    if (ins_d[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rdw_old dut0: ins=%h, want 00000000", ins_d[0]);
    end
    n_chk++;
    if (ins_d[1] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rdw_new dut1: ins=%h, want 12345678", ins_d[1]);
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd_d[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL rdw_portb dut%0d: rd=%h, want 00000000", k, rd_d[k]);
      end
    end
  endtask

  task automatic test_wrap();
    step('0, 0, 18'h10004, 4'hF, 32'hCAFEF00D, 4'h0);
    step(18'h00004, 1, 18'h00006, 4'h0, '0, 4'hF);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ins_d[k] !== 32'hCAFEF00D || rd_d[k] !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL wrap dut%0d: ins=%h rd=%h, want CAFEF00D", k, ins_d[k], rd_d[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [17:0] a;
      logic [31:0] d;
      a = 18'($urandom_range(32, 63) * 4);
      d = $urandom;
      step('0, 0, a, 4'hF, d, 4'h0);
      step({2'($urandom), a[15:2], 2'($urandom)}, 1, a, 4'h0, '0, 4'hF);
      idle(2);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (ins_d[k] !== d || rd_d[k] !== d) begin
          n_fail++;
          $display("FAIL back_to_back dut%0d: ins=%h rd=%h, want %h", k, ins_d[k], rd_d[k], d);
        end
      end
    end
  endtask

  task automatic test_stream();
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) step(18'(i * 4), 1, '0, 4'h0, '0, 4'h0);
      else step('0, 0, '0, 4'h0, '0, 4'h0);
      n_chk++;
      if (iv_d[1] !== iv_m[1] || (iv_m[1] && ins_d[1] !== ins_m[1])) begin
        n_fail++;
        $display("FAIL stream_data dut1 cyc%0d: iv=%b ins=%h, want iv=%b ins=%h",
                 i, iv_d[1], ins_d[1], iv_m[1], ins_m[1]);
      end
      if (iv_d[1] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    n_chk++;
    if (cnt != 8 || last - first != 7) begin
      n_fail++;
      $display("FAIL stream_count dut1: pulses=%0d span=%0d, want 8 consecutive", cnt, last - first + 1);
    end
    // Reset lands between edges with reads in flight and a write pending.
    for (int i = 0; i < 3; i++) step(18'(i * 4), 1, '0, 4'h0, '0, 4'hF);
    #2 rst = 1'b1;
    ins_e = 1'b1; dat_a = 18'h10; dat_we = 4'hF; dat_wd = 32'hFFFFFFFF; dat_re = 4'hF;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ins_d[k] !== 32'h0 || rd_d[k] !== 32'h0 || iv_d[k] !== 1'b0 || dv_d[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d: ins=%h rd=%h iv=%b dv=%b, want all 0",
                 k, ins_d[k], rd_d[k], iv_d[k], dv_d[k]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step('0, 0, '0, 4'h0, '0, 4'h0);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (iv_d[k] !== 1'b0 || dv_d[k] !== 1'b0 || ins_d[k] !== 32'h0) begin
          n_fail++;
          $display("FAIL stale_vld dut%0d cyc%0d: iv=%b dv=%b ins=%h, want 0 0 0",
                   k, i, iv_d[k], dv_d[k], ins_d[k]);
        end
      end
    end
    step(18'h10, 1, 18'h10, 4'h0, '0, 4'hF);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ins_d[k] !== 32'hDE55BEEF || rd_d[k] !== 32'hDE55BEEF) begin
        n_fail++;
        $display("FAIL reset_keeps_mem dut%0d: ins=%h rd=%h, want DE55BEEF", k, ins_d[k], rd_d[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [17:0] ia, da;
      logic [3:0]  we;
      ia = {2'($urandom), 14'($urandom_range(0, 63)), 2'($urandom)};
      da = {2'($urandom), 14'($urandom_range(0, 63)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) da[15:2] = ia[15:2];
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(ia, 1'($urandom), da, we, $urandom, 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (ins_d[k] !== ins_m[k] || iv_d[k] !== iv_m[k] ||
            rd_d[k] !== rd_m[k] || dv_d[k] !== dv_m[k]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: ins=%h iv=%b rd=%h dv=%b, want ins=%h iv=%b rd=%h dv=%b",
                   k, i, ins_d[k], iv_d[k], rd_d[k], dv_d[k], ins_m[k], iv_m[k], rd_m[k], dv_m[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_byte_write();
    test_lane_hold();
    test_rdw();
    test_wrap();
    test_back_to_back();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
